// File: rtl/cart_responder_if.sv
// Backing-memory port of the cartridge responder: one-cycle request pulse out,
// read data returned later with a valid strobe.
interface cart_responder_if #(
  parameter int ADDR_W = 21
);
  logic              req;
  logic              we;
  logic              ram_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              rvalid;
  logic [7:0]        rdata;

  modport master (
    output req, we, ram_sel, addr, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  req, we, ram_sel, addr, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/cart_responder.sv
// Game Boy cartridge responder with MBC1 mapper: synchronises the asynchronous
// cartridge bus, decodes mapper writes and serves reads from a backing memory.
module cart_responder #(
  parameter int ROM_ADDR_W = 21,
  parameter int RAM_ADDR_W = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        n_rd_in,
  input  logic        n_wr_in,
  input  logic        n_cs_in,
  input  logic [15:0] addr_in,
  inout  wire  [7:0]  data_io,
  cart_responder_if.master mem
);
  localparam int MEM_W = (ROM_ADDR_W > RAM_ADDR_W) ? ROM_ADDR_W : RAM_ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRIVE} rd_state_t;

  // strobe vectors are ordered {n_cs, n_wr, n_rd}
  logic [2:0]  strb_meta_reg, strb_sync_reg;
  logic [1:0]  strb_prev_reg;
  logic [15:0] addr_meta_reg, addr_sync_reg, addr_prev_reg;
  logic [7:0]  data_meta_reg, data_sync_reg, data_prev_reg;

  logic        ram_en_reg, mode_reg;
  logic [4:0]  bank1_reg;
  logic [1:0]  bank2_reg;

  rd_state_t   state_reg, state_next;
  logic [7:0]  data_reg;
  logic [15:0] cur_addr_reg;
  logic        mem_req_reg, mem_we_reg, mem_ram_sel_reg;
  logic [MEM_W-1:0] mem_addr_reg;
  logic [7:0]  mem_wdata_reg;

  logic rd_n, wr_n, cs_n, wr_prev_n, cs_prev_n;
  logic wr_det, ram_wr_go, addr_stable, rd_is_rom, rd_is_ram;
  logic rd_issue, load_ff, bus_drive;

  function automatic logic [MEM_W-1:0] rom_xlate(input logic [15:0] a, input logic [1:0] b2,
                                                 input logic [4:0] b1, input logic md);
    logic [31:0] full;
    if (a[14]) full = {11'd0, b2, b1, a[13:0]};
    else       full = {11'd0, (md ? b2 : 2'b00), 5'd0, a[13:0]};
    full = full & ((32'd1 << ROM_ADDR_W) - 32'd1);
    return full[MEM_W-1:0];
  endfunction

  function automatic logic [MEM_W-1:0] ram_xlate(input logic [15:0] a, input logic [1:0] b2,
                                                 input logic md);
    logic [31:0] full;
    full = {17'd0, (md ? b2 : 2'b00), a[12:0]};
    full = full & ((32'd1 << RAM_ADDR_W) - 32'd1);
    return full[MEM_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_meta_reg <= 3'b111;
      strb_sync_reg <= 3'b111;
      strb_prev_reg <= 2'b11;
      addr_meta_reg <= '0;
      addr_sync_reg <= '0;
      addr_prev_reg <= '0;
      data_meta_reg <= '0;
      data_sync_reg <= '0;
      data_prev_reg <= '0;
    end else begin
      strb_meta_reg <= {n_cs_in, n_wr_in, n_rd_in};
      strb_sync_reg <= strb_meta_reg;
      strb_prev_reg <= strb_sync_reg[2:1];
      addr_meta_reg <= addr_in;
      addr_sync_reg <= addr_meta_reg;
      addr_prev_reg <= addr_sync_reg;
      data_meta_reg <= data_io;
      data_sync_reg <= data_meta_reg;
      data_prev_reg <= data_sync_reg;
    end
  end

  assign rd_n      = strb_sync_reg[0];
  assign wr_n      = strb_sync_reg[1];
  assign cs_n      = strb_sync_reg[2];
  assign wr_prev_n = strb_prev_reg[0];
  assign cs_prev_n = strb_prev_reg[1];

  // Write completes on the rising strobe; the *_prev_reg values are the
  // address/data/select seen in the last cycle the strobe was still low.
  assign wr_det      = !wr_prev_n && wr_n;
  assign ram_wr_go   = wr_det && (addr_prev_reg[15:13] == 3'b101) && !cs_prev_n && ram_en_reg;
  assign addr_stable = (addr_sync_reg == addr_prev_reg);
  assign rd_is_rom   = !addr_sync_reg[15];
  assign rd_is_ram   = (addr_sync_reg[15:13] == 3'b101);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_reg <= 1'b0;
      bank1_reg  <= 5'd1;
      bank2_reg  <= 2'd0;
      mode_reg   <= 1'b0;
    end else if (wr_det) begin
      case (addr_prev_reg[15:13])
        3'b000:  ram_en_reg <= (data_prev_reg[3:0] == 4'hA);
        3'b001:  bank1_reg  <= (data_prev_reg[4:0] == 5'd0) ? 5'd1 : data_prev_reg[4:0];
        3'b010:  bank2_reg  <= data_prev_reg[1:0];
        3'b011:  mode_reg   <= data_prev_reg[0];
        default: ;
      endcase
    end
  end

  // A completing write stalls any read issue by one cycle so the read sees
  // updated mapper state and never collides with a RAM write on the port.
  always_comb begin
    state_next = state_reg;
    rd_issue   = 1'b0;
    load_ff    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rd_n && addr_stable && !wr_det) begin
          if (rd_is_rom || (rd_is_ram && !cs_n && ram_en_reg)) begin
            rd_issue   = 1'b1;
            state_next = WAIT;
          end else if (rd_is_ram && !ram_en_reg) begin
            load_ff    = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      FETCH: begin
        if (!wr_det) begin
          rd_issue   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem.rvalid) state_next = DRIVE;
      end
      DRIVE: begin
        if (rd_n) state_next = IDLE;
        else if (addr_stable && (addr_sync_reg != cur_addr_reg)) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      data_reg        <= '0;
      cur_addr_reg    <= '0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_ram_sel_reg <= 1'b0;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= ram_wr_go || rd_issue;
      mem_we_reg  <= ram_wr_go;
      if (ram_wr_go) begin
        mem_ram_sel_reg <= 1'b1;
        mem_addr_reg    <= ram_xlate(addr_prev_reg, bank2_reg, mode_reg);
        mem_wdata_reg   <= data_prev_reg;
      end else if (rd_issue) begin
        mem_ram_sel_reg <= rd_is_ram;
        mem_addr_reg    <= rd_is_ram ? ram_xlate(addr_sync_reg, bank2_reg, mode_reg)
                                     : rom_xlate(addr_sync_reg, bank2_reg, bank1_reg, mode_reg);
      end
      if (rd_issue || load_ff) cur_addr_reg <= addr_sync_reg;
      if (load_ff) data_reg <= 8'hFF;
      else if (state_reg == WAIT && mem.rvalid) data_reg <= mem.rdata;
    end
  end

  assign bus_drive   = (state_reg == DRIVE) && !rd_n && wr_n;
  assign data_io     = bus_drive ? data_reg : 8'bz;
  assign mem.req     = mem_req_reg;
  assign mem.we      = mem_we_reg;
  assign mem.ram_sel = mem_ram_sel_reg;
  assign mem.addr    = mem_addr_reg;
  assign mem.wdata   = mem_wdata_reg;
endmodule
